// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Handshake and data bundle between the EX stage and the iterative divider.
//
//   start_i       EX -> div   divide request, held high until the result is taken
//   signed_div_i  EX -> div   1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     EX -> div   32-bit dividend
//   opdata2_i     EX -> div   32-bit divisor
//   annul_i       EX -> div   flush: abandon whatever the divider is doing
//   result_o      div -> EX   {remainder[63:32], quotient[31:0]}, zero unless ready_o
//   ready_o       div -> EX   result_o is valid
//   stallreq      div -> ctrl combinational pipeline stall request
//
// master = requester (EX stage), slave = divider.
// -----------------------------------------------------------------------------
interface div_ctrl_if;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq;

    modport master (
        output start_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output annul_i,
        input  result_o,
        input  ready_o,
        input  stallreq
    );

    modport slave (
        input  start_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  annul_i,
        output result_o,
        output ready_o,
        output stallreq
    );
endinterface

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Radix-2 restoring divider for the EX stage, 32 iterations per operation.
//
// Ports:
//   clk  input   single clock, all state changes on its rising edge
//   rst  input   asynchronous, active-high reset
//   bus  div_ctrl_if.slave  request/annul in, result/ready/stallreq out
//
// Operation:
//   IDLE    waits for start_i; a zero divisor goes to DIVZERO, otherwise the
//           operand magnitudes and signs are captured and ON begins.
//   ON      32 shift/subtract steps on a 65-bit work register, then one cycle
//           of sign fixup that loads the registered result.
//   DIVZERO one cycle, result forced to zero.
//   END     ready_o high, result held until start_i drops.
//   annul_i returns to IDLE from any state and throws the work away.
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_DIVZERO = 2'b01;
    localparam logic [1:0] ST_ON      = 2'b10;
    localparam logic [1:0] ST_END     = 2'b11;

    localparam logic [5:0] LAST_CNT   = 6'(DIV_CYCLES);

    // Two's-complement magnitude when neg is set, value unchanged otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] val, input logic neg);
        logic [31:0] res;
        if (neg) begin
            res = ~val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [1:0]  state_r,     state_nxt_s;
    logic [5:0]  cnt_r,       cnt_nxt_s;
    logic [64:0] work_r,      work_nxt_s;
    logic [31:0] divisor_r,   divisor_nxt_s;
    logic        op1_neg_r,   op1_neg_nxt_s;
    logic        op2_neg_r,   op2_neg_nxt_s;
    logic        signed_r,    signed_nxt_s;
    logic [63:0] result_r,    result_nxt_s;
    logic        ready_r,     ready_nxt_s;

    logic [32:0] diff_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;
    logic        acc_op1_neg_s;
    logic        acc_op2_neg_s;

    // Trial subtraction; bit 32 set means the partial remainder is smaller than the divisor.
    assign diff_s = {1'b0, work_r[63:32]} - {1'b0, divisor_r};

    // Sign fixups applied to the finished magnitudes (remainder follows the dividend sign).
    assign quo_fix_s = mag32(work_r[31:0],  signed_r & (op1_neg_r ^ op2_neg_r));
    assign rem_fix_s = mag32(work_r[64:33], signed_r & op1_neg_r);

    // Operand signs only matter for signed divides.
    assign acc_op1_neg_s = bus.signed_div_i & bus.opdata1_i[31];
    assign acc_op2_neg_s = bus.signed_div_i & bus.opdata2_i[31];

    // Next-state and datapath update for every state; annul overrides all.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        work_nxt_s    = work_r;
        divisor_nxt_s = divisor_r;
        op1_neg_nxt_s = op1_neg_r;
        op2_neg_nxt_s = op2_neg_r;
        signed_nxt_s  = signed_r;
        result_nxt_s  = result_r;
        ready_nxt_s   = ready_r;

        if (bus.annul_i) begin
            state_nxt_s  = ST_IDLE;
            cnt_nxt_s    = 6'd0;
            work_nxt_s   = 65'd0;
            result_nxt_s = 64'h0;
            ready_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    result_nxt_s = 64'h0;
                    ready_nxt_s  = 1'b0;
                    if (bus.start_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            state_nxt_s = ST_DIVZERO;
                        end else begin
                            state_nxt_s   = ST_ON;
                            cnt_nxt_s     = 6'd0;
                            divisor_nxt_s = mag32(bus.opdata2_i, acc_op2_neg_s);
                            op1_neg_nxt_s = acc_op1_neg_s;
                            op2_neg_nxt_s = acc_op2_neg_s;
                            signed_nxt_s  = bus.signed_div_i;
                            work_nxt_s    = {32'd0, mag32(bus.opdata1_i, acc_op1_neg_s), 1'b0};
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DIVZERO: begin
                    state_nxt_s  = ST_END;
                    result_nxt_s = 64'h0;
                    ready_nxt_s  = 1'b1;
                end
                ST_ON: begin
                    if (cnt_r != LAST_CNT) begin
                        // Quotient bits enter at bit 0; partial remainder lives in [64:33].
                        if (diff_s[32]) begin
                            work_nxt_s = {work_r[63:0], 1'b0};
                        end else begin
                            work_nxt_s = {diff_s[31:0], work_r[31:0], 1'b1};
                        end
                        cnt_nxt_s = cnt_r + 6'd1;
                    end else begin
                        state_nxt_s  = ST_END;
                        result_nxt_s = {rem_fix_s, quo_fix_s};
                        ready_nxt_s  = 1'b1;
                    end
                end
                ST_END: begin
                    if (bus.start_i) begin
                        state_nxt_s = ST_END;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                        result_nxt_s = 64'h0;
                        ready_nxt_s  = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    cnt_nxt_s    = 6'd0;
                    work_nxt_s   = 65'd0;
                    result_nxt_s = 64'h0;
                    ready_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 6'd0;
            work_r    <= 65'd0;
            divisor_r <= 32'd0;
            op1_neg_r <= 1'b0;
            op2_neg_r <= 1'b0;
            signed_r  <= 1'b0;
            result_r  <= 64'h0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            work_r    <= work_nxt_s;
            divisor_r <= divisor_nxt_s;
            op1_neg_r <= op1_neg_nxt_s;
            op2_neg_r <= op2_neg_nxt_s;
            signed_r  <= signed_nxt_s;
            result_r  <= result_nxt_s;
            ready_r   <= ready_nxt_s;
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

    // Stall is combinational so EX freezes in the same cycle the request is seen.
    assign bus.stallreq = ((state_r == ST_IDLE) && bus.start_i && !bus.annul_i)
                        || (state_r == ST_ON)
                        || (state_r == ST_DIVZERO);

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Directed and randomized checks of div_ctrl against an arithmetic reference.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit
// later, so every sample sits well clear of the active edge.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_ctrl_if bus ();

    div_ctrl #(.DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: divide magnitudes with plain arithmetic, then apply signs.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic        na;
        logic        nb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] q;
        logic [63:0] r;
        if (b == 32'd0) return 64'h0;
        na = sgn & a[31];
        nb = sgn & b[31];
        ua = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        ub = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q  = ua / ub;
        r  = ua % ub;
        if (na ^ nb) q = 64'd0 - q;
        if (na)      r = 64'd0 - r;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request at cycle T and run to T+ncyc, checking busy behaviour.
    // Operands are scrambled after acceptance; the divider must ignore them.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int ncyc);
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        #1;
        chk("stall_at_T", {63'd0, bus.stallreq}, 64'd1);
        chk("ready_at_T", {63'd0, bus.ready_o}, 64'd0);
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = 1'($urandom_range(0, 1));
            #1;
            chk("stall_busy", {63'd0, bus.stallreq}, 64'd1);
            chk("ready_busy", {63'd0, bus.ready_o}, 64'd0);
        end
    endtask

    // Full operation: result at T+34 (T+2 for a zero divisor), held hold extra cycles.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int hold);
        int lat;
        lat = (b == 32'd0) ? 2 : 34;
        launch(sgn, a, b, lat - 1);
        chk("result_before_ready", bus.result_o, 64'h0);
        for (int h = 0; h <= hold; h++) begin
            tick();
            #1;
            chk("ready_end",  {63'd0, bus.ready_o}, 64'd1);
            chk("result_end", bus.result_o, exp);
            chk("stall_end",  {63'd0, bus.stallreq}, 64'd0);
        end
        bus.start_i = 1'b0;
        tick();
        #1;
        chk("ready_after", {63'd0, bus.ready_o}, 64'd0);
        chk("result_after", bus.result_o, 64'h0);
        chk("stall_after", {63'd0, bus.stallreq}, 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        checks   = 0;
        failures = 0;

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        #1;
        chk("rst_ready",  {63'd0, bus.ready_o}, 64'd0);
        chk("rst_result", bus.result_o, 64'h0);
        chk("rst_stall",  {63'd0, bus.stallreq}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        #1;
        chk("idle_stall", {63'd0, bus.stallreq}, 64'd0);

        // Directed cases with hand-computed results.
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div(1'b0, 32'd5, 32'd0, 64'h0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 3);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0, 32'hFFFF_FFFF}, 0);

        // Annul mid-operation, then a normal operation right after.
        tick();
        launch(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 10);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        bus.annul_i = 1'b0;
        #1;
        chk("annul_stall", {63'd0, bus.stallreq}, 64'd0);
        chk("annul_ready", {63'd0, bus.ready_o}, 64'd0);
        tick();
        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}, 0);

        // Start and annul together in IDLE: nothing must begin.
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd3;
        #1;
        chk("annul_start_stall", {63'd0, bus.stallreq}, 64'd0);
        tick();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        #1;
        chk("annul_start_idle", {63'd0, bus.stallreq}, 64'd0);
        tick();

        // Annul while END is held: result must vanish.
        launch(1'b0, 32'd50, 32'd3, 33);
        tick();
        #1;
        chk("end_ready", {63'd0, bus.ready_o}, 64'd1);
        chk("end_result", bus.result_o, {32'd2, 32'd16});
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("annul_end_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("annul_end_result", bus.result_o, 64'h0);
        tick();

        // Asynchronous reset in the middle of ON.
        launch(1'b0, 32'd1000, 32'd9, 15);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        #1;
        chk("rst_on_stall",  {63'd0, bus.stallreq}, 64'd0);
        chk("rst_on_ready",  {63'd0, bus.ready_o}, 64'd0);
        chk("rst_on_result", bus.result_o, 64'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("post_rst_stall", {63'd0, bus.stallreq}, 64'd0);
            chk("post_rst_ready", {63'd0, bus.ready_o}, 64'd0);
        end

        // Asynchronous reset while END is held with start still high.
        launch(1'b0, 32'd9, 32'd3, 33);
        tick();
        #1;
        chk("end2_result", bus.result_o, {32'd0, 32'd3});
        rst = 1'b1;
        #1;
        chk("rst_end_ready",  {63'd0, bus.ready_o}, 64'd0);
        chk("rst_end_result", bus.result_o, 64'h0);
        chk("rst_end_stall",  {63'd0, bus.stallreq}, 64'd1);
        bus.start_i = 1'b0;
        #1;
        chk("rst_end_stall_lo", {63'd0, bus.stallreq}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized operands checked against the reference model.
        for (int n = 0; n < 16; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = (n % 5 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_div(sgn, a, b, ref_div(sgn, a, b), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start_i  input  1  EX requests a divide; held high until ready_o is consumed.
REQ-004 SHALL have ports: signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have ports: opdata1_i  input  32  dividend.
REQ-006 SHALL have ports: opdata2_i  input  32  divisor.
REQ-007 SHALL have ports: annul_i  input  1  cancel the in-flight operation (flush).
REQ-008 SHALL have ports: result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have ports: ready_o  output  1  result_o valid.
REQ-010 SHALL have ports: stallreq  output  1  stall request to the pipeline stall controller.
REQ-011 SHALL have parameter DIV_CYCLES, default 32, meaning iteration count; only 32 is supported.

Function
REQ-012 SHALL implement FSM states IDLE, DIVZERO, ON, END.
REQ-013 IDLE, start_i=1, annul_i=0, opdata2_i=0: SHALL go to DIVZERO.
REQ-014 IDLE, start_i=1, annul_i=0, opdata2_i!=0: SHALL go to ON, latch the operands (absolute values if signed_div_i and operand[31] set), latch the sign bits and signed_div_i, set cnt=0, and set the 65-bit work register to {32'b0, |op1|, 1'b0}.
REQ-015 Operand inputs SHALL be ignored after acceptance, until IDLE is re-entered.
REQ-016 ON, cnt<32: SHALL compute diff = work[63:32] - divisor (33-bit).
REQ-017 ON, cnt<32, diff negative: work SHALL shift left 1, inserting 0.
REQ-018 ON, cnt<32, diff non-negative: work SHALL become {diff[31:0], work[31:0], 1'b1}.
REQ-019 ON, cnt<32: cnt SHALL increment after the update of REQ-017/018.
REQ-020 ON, cnt==32, signed and op1 sign XOR op2 sign: quotient SHALL be two's-complement negated.
REQ-021 ON, cnt==32, signed and op1 sign set: remainder SHALL be two's-complement negated.
REQ-022 ON, cnt==32: SHALL go to END after the sign fixups of REQ-020/021.
REQ-023 DIVZERO: result SHALL be 64'h0 and the FSM SHALL go to END next cycle.
REQ-024 END: ready_o SHALL be 1 and result_o SHALL hold the result.
REQ-025 END, start_i=0: SHALL go to IDLE next cycle.
REQ-026 END, start_i held 1: SHALL stay in END.
REQ-027 Outside END: ready_o SHALL be 0 and result_o SHALL be 64'h0.
REQ-028 stallreq SHALL be combinational: (IDLE & start_i & !annul_i) | ON | DIVZERO.
REQ-029 stallreq SHALL be 0 in END.
REQ-030 Latency, nonzero divisor: start accepted at cycle T SHALL give ready_o=1 at T+34 (32 iterations at T+1..T+32, fixup at T+33).
REQ-031 Latency, zero divisor: start accepted at cycle T SHALL give ready_o=1 at T+2.
REQ-032 annul_i=1 in any state SHALL force IDLE next cycle and discard the work register; ready_o SHALL stay 0 and stallreq SHALL drop once IDLE is reached.
REQ-033 start_i and annul_i both 1 in IDLE: SHALL stay IDLE (annul wins).
REQ-034 Signed 0x80000000 / 0xFFFFFFFF: quotient SHALL wrap to 0x80000000, remainder SHALL be 0, with no trap.
REQ-035 cnt SHALL be 6 bits; it SHALL never wrap past 32.

Reset
REQ-036 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, work=0, ready_o=0, result_o=64'h0.
REQ-037 stallreq SHALL follow from the IDLE state while rst is asserted.
REQ-038 Reset deassertion SHALL take effect at the first following clk edge.

Verification
REQ-039 Unsigned 100 / 7, start at T -> stallreq=1 during T..T+33; ready_o=1 at T+34 with result_o = {32'd2, 32'd14}.
REQ-040 Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF at T+34.
REQ-041 Divide 5 / 0 -> ready_o=1 at T+2, result_o = 64'h0; stallreq=1 only at T and T+1.
REQ-042 Unsigned 0xFFFFFFFF / 0x10 with annul_i pulse at T+10 -> IDLE at T+11, stallreq=0, ready_o never asserts; a new start at T+12 completes normally.
REQ-043 rst asserted mid-ON (T+15) -> ready_o, result_o, stallreq=0 before the next clk edge; after release, idle until start.
REQ-044 Signed 0x80000000 / 0xFFFFFFFF -> result_o = {32'h0, 32'h80000000}; start_i held high 3 extra cycles keeps ready_o=1 and the result stable.
